// File: rtl/serial_tx_en.sv
// serial_tx_en: parallel-in serial-out transmitter with a one-clock sample strobe per bit period
module serial_tx_en #(
  parameter int WIDTH = 8,
  parameter int DIV = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sd,
  output logic             sen,
  output logic             last,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);
  logic [0:0] state;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic first_bit, next_bit, advance, done;
  always_comb begin
    div_nxt = div_cnt == DMAX ? '0 : div_cnt + 1'b1;
    advance = sen && bit_cnt != BMAX;
    done = sen && bit_cnt == BMAX;
    bit_nxt = advance ? bit_cnt + 1'b1 : bit_cnt;
    sr_nxt = MSB_FIRST != 0 ? sr << 1 : sr >> 1;
    first_bit = MSB_FIRST != 0 ? load_data[WIDTH-1] : load_data[0];
    next_bit = MSB_FIRST != 0 ? sr[WIDTH-2] : sr[1];
  end
  // sen and last are registered, so they are computed from the counter values of the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      load_ready <= 1'b0;
      sd <= 1'b0;
      sen <= 1'b0;
      last <= 1'b0;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (load_valid && load_ready) begin
        state <= SHIFT;
        sr <= load_data;
        div_cnt <= '0;
        bit_cnt <= '0;
        load_ready <= 1'b0;
        busy <= 1'b1;
        sd <= first_bit;
        sen <= DMAX == '0;
      end else begin
        load_ready <= 1'b1;
      end
    end else if (done) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      load_ready <= 1'b1;
      sd <= 1'b0;
      sen <= 1'b0;
      last <= 1'b0;
      busy <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      sen <= div_nxt == DMAX;
      last <= div_nxt == DMAX && bit_nxt == BMAX;
      if (advance) begin
        sr <= sr_nxt;
        sd <= next_bit;
      end
    end
  end
endmodule

// File: tb/tb_serial_tx_en.sv
// tb_serial_tx_en: three configurations driven in parallel and checked against a frame-position model
module tb_serial_tx_en;
  logic clk = 1'b0, reset = 1'b1, lv = 1'b0;
  logic [7:0] ld = '0;
  logic [2:0] rdy, sd, sen, last, busy;
  int checks = 0, errors = 0;
  int k[3];
  logic [7:0] w[3];
  bit up = 1'b0;
  int rise[$];
  logic [7:0] frames[$];
  typedef struct {logic [7:0] word; logic [7:0] seq_msb; logic [7:0] seq_lsb;} vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  serial_tx_en #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u0 (.clk(clk), .reset(reset), .load_valid(lv), .load_data(ld),
    .load_ready(rdy[0]), .sd(sd[0]), .sen(sen[0]), .last(last[0]), .busy(busy[0]));
  serial_tx_en #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u1 (.clk(clk), .reset(reset), .load_valid(lv), .load_data(ld),
    .load_ready(rdy[1]), .sd(sd[1]), .sen(sen[1]), .last(last[1]), .busy(busy[1]));
  serial_tx_en #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) u2 (.clk(clk), .reset(reset), .load_valid(lv), .load_data(ld),
    .load_ready(rdy[2]), .sd(sd[2]), .sen(sen[2]), .last(last[2]), .busy(busy[2]));

  function automatic int dv(input int n);
    return n == 2 ? 4 : 1;
  endfunction

  function automatic bit ms(input int n);
    return n != 1;
  endfunction

  // k counts clocks since the accept edge (0 = idle); every output follows from k and the word
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++)
      if (reset) k[n] <= 0;
      else if (k[n] == 0) begin
        if (lv && up) begin
          k[n] <= 1;
          w[n] <= ld;
        end
      end else k[n] <= k[n] == 8 * dv(n) ? 0 : k[n] + 1;
    up <= !reset;
  end

  function automatic logic [4:0] model(input int n);
    int i;
    logic b;
    if (k[n] == 0) return {up, 4'b0000};
    i = (k[n] - 1) / dv(n);
    b = ms(n) ? w[n][7-i] : w[n][i];
    return {1'b0, 1'b1, (k[n] % dv(n)) == 0, k[n] == 8 * dv(n), b};
  endfunction

  task automatic tick;
    logic [4:0] a, e;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      a = {rdy[n], busy[n], sen[n], last[n], sd[n]};
      e = model(n);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model u%0d t=%0t rdy/busy/sen/last/sd got %b expected %b", n, $time, a, e);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drain;
    int c = 0;
    while (!(rdy === 3'b111 && busy === 3'b000) && c < 60) begin
      tick;
      c++;
    end
    check("drain_timeout", c < 60, 1);
  endtask

  task automatic run_frame(input logic [7:0] word, input logic [7:0] smsb, input logic [7:0] slsb);
    logic [7:0] cap[3];
    logic [7:0] rec = '0;
    int ns[3], nb[3], nl[3];
    for (int n = 0; n < 3; n++) begin
      cap[n] = '0;
      ns[n] = 0;
      nb[n] = 0;
      nl[n] = 0;
    end
    drain;
    lv = 1'b1;
    ld = word;
    tick;
    lv = 1'b0;
    ld = 8'($urandom);
    for (int c = 0; c < 40 && busy != 3'b000; c++) begin
      for (int n = 0; n < 3; n++) begin
        if (sen[n]) begin
          cap[n] = {cap[n][6:0], sd[n]};
          ns[n]++;
          if (n == 1) rec = {sd[n], rec[7:1]};
        end
        if (busy[n]) nb[n]++;
        if (sen[n] && last[n]) nl[n]++;
      end
      tick;
    end
    for (int n = 0; n < 3; n++) begin
      check($sformatf("seq_u%0d_%h", n, word), cap[n], n == 1 ? slsb : smsb);
      check($sformatf("nsen_u%0d_%h", n, word), ns[n], 8);
      check($sformatf("busy_len_u%0d_%h", n, word), nb[n], 8 * dv(n));
      check($sformatf("nlast_u%0d_%h", n, word), nl[n], 1);
    end
    check($sformatf("sipo_lsb_%h", word), rec, word);
  endtask

  initial begin
    logic [7:0] cp = '0;
    bit pb = 1'b0;
    int ns = 0;
    tbl[0] = '{8'hC1, 8'b11000001, 8'b10000011};
    tbl[1] = '{8'hA5, 8'b10100101, 8'b10100101};
    tbl[2] = '{8'h3C, 8'b00111100, 8'b00111100};
    tbl[3] = '{8'h12, 8'b00010010, 8'b01001000};
    tbl[4] = '{8'h80, 8'b10000000, 8'b00000001};
    tbl[5] = '{8'hFF, 8'b11111111, 8'b11111111};
    // power-on: reset held with load_valid high
    lv = 1'b1;
    ld = 8'hC1;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    check("por_ready", rdy, 3'b111);
    check("por_no_accept", busy, 3'b000);
    tick;
    check("por_accept", busy, 3'b111);
    lv = 1'b0;
    drain;
    foreach (tbl[i]) run_frame(tbl[i].word, tbl[i].seq_msb, tbl[i].seq_lsb);
    // load_valid held through a frame while load_data changes
    drain;
    lv = 1'b1;
    ld = 8'hC1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 3) ld = 8'hFF;
      if (busy[0] && !pb) rise.push_back(c);
      pb = busy[0];
      if (busy[0]) check("busy_ready_low", rdy[0], 0);
      if (sen[0]) cp = {cp[6:0], sd[0]};
      if (sen[0] && last[0]) frames.push_back(cp);
    end
    lv = 1'b0;
    check("accept_spacing", rise.size() >= 2 ? rise[1] - rise[0] : -1, 9);
    check("frame1_word", frames.size() >= 1 ? int'(frames[0]) : -1, 8'hC1);
    check("frame2_word", frames.size() >= 2 ? int'(frames[1]) : -1, 8'hFF);
    // reset after the third strobe
    drain;
    lv = 1'b1;
    ld = 8'hC1;
    tick;
    lv = 1'b0;
    for (int c = 0; c < 20 && ns < 3; c++) begin
      if (sen[0]) ns++;
      if (ns < 3) tick;
    end
    check("third_sen_seen", ns, 3);
    reset = 1'b1;
    tick;
    check("rst_outputs", {rdy, busy, sen, last, sd}, 0);
    reset = 1'b0;
    ns = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (c == 0) check("rst_release_ready", rdy, 3'b111);
      if (sen != 3'b000) ns++;
    end
    check("rst_no_sen", ns, 0);
    run_frame(8'h3C, 8'b00111100, 8'b00111100);
    // random traffic with occasional resets
    for (int c = 0; c < 500; c++) begin
      lv = ($urandom % 3) == 0;
      ld = 8'($urandom);
      reset = ($urandom % 80) == 0;
      tick;
    end
    reset = 1'b0;
    lv = 1'b0;
    drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
